// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ producers.
// A grant is held for a whole burst, ended by req_last or by the MAX_BURST beat cap.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                        wclk,
  input  logic                        wrst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        wfull,
  output logic                        winc,
  output logic [DATA_W-1:0]           wdata,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // Handshake: a beat moves on a cycle where req_valid[i] and req_ready[i] are both
  // high; ready is only offered to the current owner and only while the FIFO is not full.
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   last_grant;
  logic [CNT_W-1:0]   beat_cnt;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               ready_o;
  logic               fire;
  logic               rel_burst;

  // Search starts just after the previous owner, so it ends up with lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    busy      = (state == XFER);
    ready_o   = busy & ~wfull;
    req_ready = ready_o ? (NUM_REQ'(1) << owner) : '0;
    winc      = busy & req_valid[owner] & ~wfull;
    fire      = winc;
    rel_burst = req_last[owner] | (beat_cnt == CNT_W'(MAX_BURST - 1));
    wdata     = busy ? req_data[owner*DATA_W +: DATA_W] : '0;
    grant_id  = owner;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner      <= pick_idx;
            last_grant <= pick_idx;
            beat_cnt   <= '0;
            state      <= XFER;
          end
        end
        XFER: begin
          if (fire) begin
            if (rel_burst) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: round robin, burst hold, backpressure,
// burst cap, owner bubble and mid-burst reset, with a beat scoreboard.
module tb_fifo_wr_arbiter;

  logic        wclk;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic [1:0]  grant_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_beat;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(16)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .grant_id(grant_id), .busy(busy)
  );

  // clock / reset
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  // Check an accepting XFER cycle and queue the beat it will write.
  task automatic beat_chk(input string tag, input int g, input logic [7:0] d);
    #1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_grant"}, 32'(grant_id), 32'(g));
    chk({tag, "_winc"}, 32'(winc), 32'd1);
    chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << g));
    chk({tag, "_wdata"}, 32'(wdata), 32'(d));
    exp_q.push_back({4'(g), d});
  endtask

  task automatic stall_chk(input string tag, input int g, input logic [3:0] rdy);
    #1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_grant"}, 32'(grant_id), 32'(g));
    chk({tag, "_winc"}, 32'(winc), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'(rdy));
  endtask

  task automatic idle_chk(input string tag);
    #1;
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_winc"}, 32'(winc), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  // scoreboard: every written beat must match the head of the expected queue
  always @(negedge wclk) begin
    if (wrst_n && winc) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL beat_unexpected observed=%0h expected=none", {2'b00, grant_id, wdata});
      end
      if (exp_q.size() != 0) begin
        exp_beat = exp_q.pop_front();
        chk("beat", 32'({2'b00, grant_id, wdata}), 32'(exp_beat));
      end
    end
  end

  initial begin
    wrst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; wfull = 1'b0;
    tick(); tick();
    idle_chk("rst");
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    wrst_n = 1'b1;
    tick();

    // T2 round robin, single-beat bursts: grants 0,1,2,3,0
    req_valid = 4'hF; req_last = 4'hF;
    for (int i = 0; i < 4; i++) set_data(i, 8'(32'hA0 + i));
    idle_chk("t2_idle0");
    for (int n = 0; n < 5; n++) begin
      tick();
      beat_chk("t2_xfer", n % 4, 8'(32'hA0 + (n % 4)));
      tick();
      idle_chk("t2_idle");
    end
    req_valid = '0; req_last = '0;

    // T3 burst hold: req1 five beats, req2 waits
    req_valid = 4'b0110; req_last = 4'b0100;
    set_data(1, 8'h10); set_data(2, 8'h55);
    tick();
    for (int b = 0; b < 5; b++) begin
      set_data(1, 8'(32'h10 + b));
      req_last[1] = (b == 4);
      beat_chk("t3_burst", 1, 8'(32'h10 + b));
      tick();
    end
    req_valid = 4'b0100;
    idle_chk("t3_rel");
    tick();
    beat_chk("t3_req2", 2, 8'h55);
    tick();
    req_valid = '0; req_last = '0;

    // T4 backpressure mid-burst of req0
    req_valid = 4'b0001; set_data(0, 8'h30);
    tick();
    for (int b = 0; b < 6; b++) begin
      if (b == 2) begin
        wfull = 1'b1;
        for (int s = 0; s < 3; s++) begin
          stall_chk("t4_full", 0, 4'b0000);
          tick();
        end
        wfull = 1'b0;
      end
      set_data(0, 8'(32'h30 + b));
      req_last[0] = (b == 5);
      beat_chk("t4_burst", 0, 8'(32'h30 + b));
      tick();
    end
    req_valid = '0; req_last = '0;
    idle_chk("t4_rel");

    // T5 burst cap: req2 streams 20 beats without last, req0 waiting
    req_valid = 4'b0101; req_last = 4'b0001; set_data(0, 8'h77);
    tick();
    for (int b = 0; b < 16; b++) begin
      set_data(2, 8'(32'h60 + b));
      beat_chk("t5_first", 2, 8'(32'h60 + b));
      tick();
    end
    idle_chk("t5_cap");
    tick();
    beat_chk("t5_req0", 0, 8'h77);
    tick();
    req_valid = 4'b0100;
    idle_chk("t5_gap");
    tick();
    for (int b = 16; b < 20; b++) begin
      set_data(2, 8'(32'h60 + b));
      req_last[2] = (b == 19);
      beat_chk("t5_resume", 2, 8'(32'h60 + b));
      tick();
    end
    req_valid = '0; req_last = '0;
    idle_chk("t5_done");

    // T6 owner bubble: req3 drops valid for 2 cycles, req0 must wait
    req_valid = 4'b1001; req_last = 4'b0001; set_data(0, 8'h88);
    tick();
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        req_valid[3] = 1'b0;
        for (int s = 0; s < 2; s++) begin
          set_data(0, 8'(32'h88 + s + 1));
          stall_chk("t6_bubble", 3, 4'b1000);
          chk("t6_bubble_wdata", 32'(wdata), 32'h91);
          tick();
        end
        req_valid[3] = 1'b1;
        set_data(0, 8'h88);
      end
      set_data(3, 8'(32'h90 + b));
      req_last[3] = (b == 3);
      beat_chk("t6_burst", 3, 8'(32'h90 + b));
      tick();
    end
    idle_chk("t6_rel");
    tick();
    beat_chk("t6_req0", 0, 8'h88);
    tick();
    req_valid = '0; req_last = '0;

    // T1 reset mid-burst, then requester 0 beats requester 3
    req_valid = 4'b0010; set_data(1, 8'hC0);
    tick();
    #1;
    chk("t1_pre_winc", 32'(winc), 32'd1);
    chk("t1_pre_grant", 32'(grant_id), 32'd1);
    wrst_n = 1'b0;
    #1;
    idle_chk("t1_rst");
    chk("t1_rst_grant", 32'(grant_id), 32'd0);
    chk("t1_rst_wdata", 32'(wdata), 32'd0);
    req_valid = 4'b1001; req_last = 4'b1001;
    set_data(0, 8'hD0); set_data(3, 8'hD3);
    tick();
    wrst_n = 1'b1;
    idle_chk("t1_idle");
    tick();
    beat_chk("t1_req0", 0, 8'hD0);
    tick();
    tick();
    beat_chk("t1_req3", 3, 8'hD3);
    tick();
    req_valid = '0; req_last = '0;
    tick(); tick();
    idle_chk("end_idle");
    chk("q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
